lfsr_seq_checker: RTL and testbench

//  Downstream consumer of the 26-bit LFSR stage. Accepts one LFSR word per valid cycle.

---
 rtl/lfsr_seq_checker.sv | 143 ++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for a 26-bit x^26+x^6+x^2+x+1 LFSR stream: seeds from
// the incoming words, locks after LOCK_CNT correct predictions, then counts mispredictions.
module lfsr_seq_checker #(
   parameter int WIDTH    = 26,
   parameter int LOCK_CNT = 4,
   parameter int MAX_MISS = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             sync_lost,
   output logic [ERR_W-1:0] err_count,
   output logic [31:0]      word_count
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(MAX_MISS + 1);
   localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_CNT);
   localparam logic [MISS_W-1:0]  MISS_LAST = MISS_W'(MAX_MISS - 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   pred_q, pred_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic               sync_lost_q, sync_lost_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
   logic [31:0]        word_cnt_q, word_cnt_d;

   // Feedback taps are bits 25, 5, 1 and 0; the MSB shifts out.
   function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], x[WIDTH-1] ^ x[5] ^ x[1] ^ x[0]};
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves it
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      state_d     = state_q;
      pred_d      = pred_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_pulse_d = 1'b0;
      sync_lost_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      word_cnt_d  = word_cnt_q;

      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               // All-zero is the LFSR lock-up value and can never seed a valid sequence.
               if (din != '0) begin
                  pred_d  = nxt(din);
                  match_d = '0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               if (din == pred_q) begin
                  pred_d  = nxt(din);
                  match_d = match_q + MATCH_W'(1);
                  if (match_d == LOCK_V) state_d = LOCKED;
               end else if (din != '0) begin
                  pred_d  = nxt(din);
                  match_d = '0;
               end else begin
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               // Flywheel: the prediction free-runs so a corrupt word cannot reseed it.
               pred_d     = nxt(pred_q);
               word_cnt_d = word_cnt_q + 32'd1;
               if (din == pred_q) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                  if (miss_q == MISS_LAST) begin
                     state_d     = HUNT;
                     sync_lost_d = 1'b1;
                     miss_d      = '0;
                  end else begin
                     miss_d = miss_q + MISS_W'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (clear) begin
         err_cnt_d  = '0;
         word_cnt_d = '0;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the
      // pre-edge values, independent of statement order within the block.
      if (rst) begin
         state_q     <= HUNT;
         pred_q      <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         sync_lost_q <= 1'b0;
         err_cnt_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         sync_lost_q <= sync_lost_d;
         err_cnt_q   <= err_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign sync_lost  = sync_lost_q;
   assign err_count  = err_cnt_q;
   assign word_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus a randomized stream compared
// every cycle against a behavioural model of the checker's rules.
module tb_lfsr_seq_checker;

   localparam int          LOCK_CNT = 4;
   localparam int          MAX_MISS = 3;
   localparam logic [25:0] TAPS     = 26'h2000023;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din_valid = 1'b0;
   logic [25:0] din = '0;
   logic        clear = 1'b0;
   logic        locked, err_pulse, sync_lost;
   logic [15:0] err_count;
   logic [31:0] word_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [25:0] cur;

   // Model state: seeded/locked flags, run of correct predictions, run of misses.
   bit          m_seeded, m_locked, m_ep, m_sl;
   int          m_run, m_miss;
   logic [25:0] m_pred;
   logic [15:0] m_err;
   logic [31:0] m_words;

   always #5 clk = ~clk;

   lfsr_seq_checker dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din        (din),
      .clear      (clear),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .sync_lost  (sync_lost),
      .err_count  (err_count),
      .word_count (word_count)
   );

   function automatic logic [25:0] lfsr_next(input logic [25:0] x);
      logic fb;
      fb = ^(x & TAPS);
      return 26'((x << 1) | 26'(fb));
   endfunction

   task automatic model_update(input logic r, input logic v, input logic [25:0] w, input logic c);
      m_ep = 0;
      m_sl = 0;
      if (r) begin
         m_seeded = 0; m_locked = 0; m_run = 0; m_miss = 0;
         m_pred = '0; m_err = '0; m_words = '0;
         return;
      end
      if (v) begin
         if (m_locked) begin
            m_words = m_words + 32'd1;
            if (w == m_pred) m_miss = 0;
            else begin
               m_ep = 1;
               if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
               m_miss++;
               if (m_miss == MAX_MISS) begin
                  m_locked = 0; m_seeded = 0; m_sl = 1; m_miss = 0;
               end
            end
            m_pred = lfsr_next(m_pred);
         end else if (!m_seeded) begin
            if (w != 0) begin
               m_seeded = 1; m_run = 0; m_pred = lfsr_next(w);
            end
         end else if (w == m_pred) begin
            m_run++;
            m_pred = lfsr_next(w);
            if (m_run == LOCK_CNT) m_locked = 1;
         end else if (w != 0) begin
            m_run = 0; m_pred = lfsr_next(w);
         end else begin
            m_seeded = 0;
         end
      end
      if (c) begin
         m_err = '0;
         m_words = '0;
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [25:0] w, input logic c);
      @(negedge clk);
      rst = r; din_valid = v; din = w; clear = c;
      @(posedge clk);
      model_update(r, v, w, c);
      #1;
   endtask

   task automatic feed_clean(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, cur, 1'b0);
         cur = lfsr_next(cur);
      end
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 26'h0, 1'b0);
      step(1'b1, 1'b0, 26'h0, 1'b0);
      n_checks++;
      if ({locked, err_pulse, sync_lost, err_count, word_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b/%b/%b/%h/%h expected all zero",
                  locked, err_pulse, sync_lost, err_count, word_count);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 26'($urandom), 1'b0);
         n_checks++;
         if ({locked, err_pulse, sync_lost, err_count, word_count} !== '0) begin
            n_fail++;
            $display("FAIL idle_invalid: got %b/%b/%b/%h/%h expected all zero",
                     locked, err_pulse, sync_lost, err_count, word_count);
         end
      end
   endtask

   task automatic test_lock();
      cur = 26'h1;
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b1, cur, 1'b0);
         cur = lfsr_next(cur);
         n_checks++;
         if (locked !== 1'(i == 5)) begin
            n_fail++;
            $display("FAIL lock_word%0d: locked=%b expected %b", i, locked, 1'(i == 5));
         end
      end
      n_checks++;
      if (word_count !== 32'd0) begin
         n_fail++;
         $display("FAIL lock_wc0: word_count=%0d expected 0", word_count);
      end
      feed_clean(10);
      n_checks++;
      if (word_count !== 32'd10 || err_count !== 16'd0 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_clean: wc=%0d ec=%0d locked=%b expected 10/0/1",
                  word_count, err_count, locked);
      end
   endtask

   task automatic test_single_error();
      step(1'b0, 1'b1, cur ^ 26'h1, 1'b0);
      cur = lfsr_next(cur);
      n_checks++;
      if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1 || sync_lost !== 1'b0) begin
         n_fail++;
         $display("FAIL single_err: ep=%b ec=%0d locked=%b sl=%b expected 1/1/1/0",
                  err_pulse, err_count, locked, sync_lost);
      end
      feed_clean(1);
      n_checks++;
      if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL no_reseed: ep=%b ec=%0d locked=%b expected 0/1/1",
                  err_pulse, err_count, locked);
      end
   endtask

   task automatic test_burst_loss();
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b1, cur ^ 26'(32'h1 << (i + 3)), 1'b0);
         cur = lfsr_next(cur);
         n_checks++;
         if (err_pulse !== 1'b1 || err_count !== 16'(1 + i) || sync_lost !== 1'(i == 3)
             || locked !== 1'(i != 3)) begin
            n_fail++;
            $display("FAIL burst_err%0d: ep=%b ec=%0d sl=%b locked=%b expected 1/%0d/%b/%b",
                     i, err_pulse, err_count, sync_lost, locked, 1 + i, 1'(i == 3), 1'(i != 3));
         end
      end
      for (int i = 1; i <= 5; i++) begin
         feed_clean(1);
         n_checks++;
         if (locked !== 1'(i == 5) || sync_lost !== 1'b0 || err_count !== 16'd4) begin
            n_fail++;
            $display("FAIL relock_word%0d: locked=%b sl=%b ec=%0d expected %b/0/4",
                     i, locked, sync_lost, err_count, 1'(i == 5));
         end
      end
   endtask

   task automatic test_zero_hunt();
      step(1'b1, 1'b0, 26'h0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 26'h0, 1'b0);
      n_checks++;
      if (locked !== 1'b0 || err_count !== 16'd0 || word_count !== 32'd0) begin
         n_fail++;
         $display("FAIL zero_hunt: locked=%b ec=%0d wc=%0d expected 0/0/0",
                  locked, err_count, word_count);
      end
      cur = 26'($urandom) | 26'h100;
      feed_clean(4);
      n_checks++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_seed_early: locked=%b expected 0", locked);
      end
      feed_clean(1);
      n_checks++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_seed_lock: locked=%b expected 1", locked);
      end
   endtask

   task automatic test_toggle_clear_rst();
      logic [31:0] wc0;
      wc0 = m_words;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) feed_clean(1);
         else step(1'b0, 1'b0, 26'($urandom), 1'b0);
         n_checks++;
         if (err_pulse !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_c%0d: ep=%b locked=%b expected 0/1", i, err_pulse, locked);
         end
      end
      n_checks++;
      if (word_count !== wc0 + 32'd10 || err_count !== 16'd0) begin
         n_fail++;
         $display("FAIL toggle_counts: wc=%0d ec=%0d expected %0d/0",
                  word_count, err_count, wc0 + 32'd10);
      end
      step(1'b0, 1'b1, cur ^ 26'h3, 1'b0);
      cur = lfsr_next(cur);
      step(1'b0, 1'b1, cur ^ 26'h3, 1'b1);
      cur = lfsr_next(cur);
      n_checks++;
      if (err_count !== 16'd0 || word_count !== 32'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_vs_err: ec=%0d wc=%0d ep=%b locked=%b expected 0/0/1/1",
                  err_count, word_count, err_pulse, locked);
      end
      feed_clean(2);
      step(1'b1, 1'b1, cur, 1'b0);
      n_checks++;
      if ({locked, err_pulse, sync_lost, err_count, word_count} !== '0) begin
         n_fail++;
         $display("FAIL rst_locked: got %b/%b/%b/%h/%h expected all zero",
                  locked, err_pulse, sync_lost, err_count, word_count);
      end
   endtask

   task automatic test_random();
      logic        v, c, r;
      logic [25:0] w;
      int          pick;
      step(1'b1, 1'b0, 26'h0, 1'b0);
      cur = 26'($urandom) | 26'h1;
      for (int i = 0; i < 3000; i++) begin
         v    = ($urandom % 4) != 0;
         c    = ($urandom % 64) == 0;
         r    = ($urandom % 700) == 0;
         pick = int'($urandom % 100);
         if (pick < 3)       w = 26'h0;
         else if (pick < 9)  w = cur ^ 26'(32'h1 << ($urandom % 26));
         else if (pick < 11) begin
            cur = 26'($urandom) | 26'h1;
            w   = cur;
         end else            w = cur;
         step(r, v, w, c);
         if (v) cur = lfsr_next(cur);
         n_checks++;
         if ({locked, err_pulse, sync_lost, err_count, word_count}
             !== {m_locked, m_ep, m_sl, m_err, m_words}) begin
            n_fail++;
            $display("FAIL random_c%0d: got %b/%b/%b/%h/%h expected %b/%b/%b/%h/%h", i,
                     locked, err_pulse, sync_lost, err_count, word_count,
                     m_locked, m_ep, m_sl, m_err, m_words);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_single_error();
      test_burst_loss();
      test_zero_hunt();
      test_toggle_clear_rst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
